icache_dm: RTL and testbench

- Parametrised direct-mapped instruction cache with multiple tagged lines.
- Successor to the single-window instruction buffer: many lines instead of one window, a request/grant handshake toward the memory arbiter, flush support and an echoed PC.
- Sits between the instruction fetcher and the memory controller.
- Refills one whole line per miss over the byte-serial memory port.

---
 rtl/icache_dm.sv | 212 +++++++++++++++++++++
 tb/tb_icache_dm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache refilling whole lines over a byte-serial memory port.
// Optional hit/miss statistics outputs are enabled by defining ICACHE_STATS_EN.
module icache_dm #(
    parameter int LINE_BYTES_LOG  = 4,
    parameter int LINES_LOG       = 5,
    parameter int ADDR_LIMIT_BITS = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        flush_in,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_byte,
    input  logic        mem_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int L       = 1 << LINE_BYTES_LOG;
    localparam int N       = 1 << LINES_LOG;
    localparam int TAG_LSB = LINE_BYTES_LOG + LINES_LOG;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int LINE_W  = 32 - LINE_BYTES_LOG;
    localparam int CNT_W   = LINE_BYTES_LOG + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DRAIN
    } state_t;

    state_t             state_q;
    logic [LINE_W-1:0]  line_q;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic [N-1:0]       valid_q;
    logic [TAG_W-1:0]   tag_q [N];
    logic [7:0]         data_q [N*L];
    logic               inst_valid_q;
    logic [31:0]        inst_out_q;
    logic [31:0]        inst_pc_q;
    logic               mem_req_q;
    logic [31:0]        mem_addr_q;
    logic               busy_q;

    logic [LINES_LOG-1:0]      req_idx;
    logic [TAG_W-1:0]          req_tag;
    logic [LINE_BYTES_LOG-3:0] req_word;
    logic                      in_range;
    logic                      hit;
    logic [31:0]               rd_word;
    logic [LINES_LOG-1:0]      refill_idx;
    logic [TAG_W-1:0]          refill_tag;
    logic                      grant_now;
    logic                      byte_accept;
    logic                      line_done;
    logic                      unused_pc_bits;

    assign req_idx  = req_pc[TAG_LSB-1:LINE_BYTES_LOG];
    assign req_tag  = req_pc[31:TAG_LSB];
    assign req_word = req_pc[LINE_BYTES_LOG-1:2];
    assign in_range = (req_pc[31:ADDR_LIMIT_BITS] == '0);
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign rd_word  = {data_q[{req_idx, req_word, 2'd3}],
                       data_q[{req_idx, req_word, 2'd2}],
                       data_q[{req_idx, req_word, 2'd1}],
                       data_q[{req_idx, req_word, 2'd0}]};
    assign unused_pc_bits = ^req_pc[1:0];

    assign refill_idx  = line_q[LINES_LOG-1:0];
    assign refill_tag  = line_q[LINE_W-1:LINES_LOG];
    assign grant_now   = mem_req_q && mem_grant;
    // A byte is only accepted while one is outstanding, so stray strobes are dropped.
    assign byte_accept = (state_q == REFILL) && mem_valid && (issue_cnt_q != recv_cnt_q);
    assign line_done   = byte_accept && (recv_cnt_q == CNT_LAST);
    assign issue_cnt_d = issue_cnt_q + CNT_ONE;
    assign recv_cnt_d  = recv_cnt_q + CNT_ONE;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            line_q       <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            valid_q      <= '0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            inst_valid_q <= 1'b0;
            if (flush_in) begin
                valid_q     <= '0;
                mem_req_q   <= 1'b0;
                issue_cnt_q <= '0;
                recv_cnt_q  <= '0;
                // A byte granted on this edge still arrives next cycle; swallow it in DRAIN.
                if (state_q == REFILL && grant_now) begin
                    state_q <= DRAIN;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (req_valid && in_range) begin
                            if (hit) begin
                                inst_valid_q <= 1'b1;
                                inst_out_q   <= rd_word;
                                inst_pc_q    <= {req_pc[31:2], 2'b00};
                            end else begin
                                line_q           <= req_pc[31:LINE_BYTES_LOG];
                                valid_q[req_idx] <= 1'b0;
                                mem_req_q        <= 1'b1;
                                mem_addr_q       <= {req_pc[31:LINE_BYTES_LOG], {LINE_BYTES_LOG{1'b0}}};
                                issue_cnt_q      <= '0;
                                recv_cnt_q       <= '0;
                                state_q          <= REFILL;
                                busy_q           <= 1'b1;
                            end
                        end
                    end
                    REFILL: begin
                        if (grant_now) begin
                            issue_cnt_q <= issue_cnt_d;
                            if (issue_cnt_d == CNT_FULL) begin
                                mem_req_q <= 1'b0;
                            end else begin
                                mem_addr_q <= {line_q, issue_cnt_d[LINE_BYTES_LOG-1:0]};
                            end
                        end
                        if (byte_accept) begin
                            recv_cnt_q <= recv_cnt_d;
                            if (line_done) begin
                                valid_q[refill_idx] <= 1'b1;
                                mem_req_q           <= 1'b0;
                                issue_cnt_q         <= '0;
                                recv_cnt_q          <= '0;
                                state_q             <= IDLE;
                                busy_q              <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (byte_accept && !flush_in) begin
            data_q[{refill_idx, recv_cnt_q[LINE_BYTES_LOG-1:0]}] <= mem_byte;
        end
        if (line_done && !flush_in) begin
            tag_q[refill_idx] <= refill_tag;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign busy       = busy_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (!flush_in && state_q == IDLE && req_valid && in_range) begin
            if (hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end else begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: table of single-cycle lookups plus refill, stall,
// eviction, flush and asynchronous-reset sequences against a byte-pattern memory.
module tb_icache_dm;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        flush_in;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_byte;
    logic        mem_valid;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          stall_mode = 1'b0;
    logic        g_q = 1'b0;
    logic [31:0] a_q = '0;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
    } vec_t;

    localparam int NV = 11;
    vec_t tv [NV];

    icache_dm #(
        .LINE_BYTES_LOG (4),
        .LINES_LOG      (5),
        .ADDR_LIMIT_BITS(17)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .inst_valid(inst_valid),
        .inst_out  (inst_out),
        .inst_pc   (inst_pc),
        .flush_in  (flush_in),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_grant (mem_grant),
        .mem_byte  (mem_byte),
        .mem_valid (mem_valid)
    );

    always #5 clk_in = ~clk_in;

    // Memory side: remember what was granted this cycle, answer it next cycle.
    always @(negedge clk_in) begin
        g_q = mem_req && mem_grant;
        a_q = mem_addr;
    end

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {pat(a + 32'd3), pat(a + 32'd2), pat(a + 32'd1), pat(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        mem_valid = g_q;
        mem_byte  = pat(a_q);
        mem_grant = stall_mode ? ~mem_grant : 1'b1;
    endtask

    task automatic do_miss(input logic [31:0] pc, input bit stall, input int exp_lat, input string nm);
        int          cyc;
        int          win;
        int          idx;
        bit          seen;
        logic [31:0] base;
        base       = {pc[31:4], 4'h0};
        win        = stall ? 32 : 16;
        stall_mode = stall;
        mem_grant  = 1'b1;
        req_valid  = 1'b1;
        req_pc     = pc;
        cyc        = 0;
        seen       = 1'b0;
        while (!seen && cyc < 100) begin
            step();
            cyc++;
            if (cyc <= win) begin
                idx = stall ? (cyc - 1) / 2 : cyc - 1;
                chk($sformatf("%s_addr_c%0d", nm, cyc), mem_req ? mem_addr : 32'hFFFF_FFFF,
                    base + 32'(idx));
            end
            if (inst_valid) seen = 1'b1;
        end
        req_valid  = 1'b0;
        stall_mode = 1'b0;
        chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, "_inst"}, inst_out, exp_word({pc[31:2], 2'b00}));
        chk({nm, "_pc"}, inst_pc, {pc[31:2], 2'b00});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h0706_0504, 32'h0000_0004};
        tv[1]  = '{1'b1, 32'h0000_0008, 1'b1, 32'h0B0A_0908, 32'h0000_0008};
        tv[2]  = '{1'b1, 32'h0000_000C, 1'b1, 32'h0F0E_0D0C, 32'h0000_000C};
        tv[3]  = '{1'b1, 32'h0000_1236, 1'b1, 32'h1617_1415, 32'h0000_1234};
        tv[4]  = '{1'b0, 32'h0000_1234, 1'b0, 32'h0,        32'h0};
        tv[5]  = '{1'b1, 32'h0002_0000, 1'b0, 32'h0,        32'h0};
        tv[6]  = '{1'b1, 32'h0000_1230, 1'b1, 32'h1213_1011, 32'h0000_1230};
        tv[7]  = '{1'b1, 32'h0000_123C, 1'b1, 32'h1E1F_1C1D, 32'h0000_123C};
        tv[8]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0302_0100, 32'h0000_0000};
        tv[9]  = '{1'b1, 32'h0002_0004, 1'b0, 32'h0,        32'h0};
        tv[10] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0,        32'h0};

        rst_in    = 1'b1;
        req_valid = 1'b0;
        req_pc    = '0;
        flush_in  = 1'b0;
        mem_grant = 1'b1;
        mem_valid = 1'b0;
        mem_byte  = '0;

        #12;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_out", inst_out, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        do_miss(32'h0000_0000, 1'b0, 19, "cold");
        do_miss(32'h0000_1230, 1'b1, 35, "stall");

        for (int i = 0; i < NV; i++) begin
            req_valid = tv[i].rv;
            req_pc    = tv[i].pc;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(tv[i].ev));
            chk($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'd0);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            if (tv[i].ev) begin
                chk($sformatf("vec%0d_inst", i), inst_out, tv[i].ei);
                chk($sformatf("vec%0d_pc", i), inst_pc, tv[i].ep);
            end
        end
        req_valid = 1'b0;
        step();

        do_miss(32'h0000_0200, 1'b0, 19, "evict");
        do_miss(32'h0000_0000, 1'b0, 19, "remiss");

        req_valid = 1'b1;
        req_pc    = 32'h0000_0680;
        step();
        chk("flush_start", mem_req ? mem_addr : 32'hFFFF_FFFF, 32'h0000_0680);
        req_valid = 1'b0;
        repeat (5) step();
        chk("flush_pre_busy", 32'(busy), 32'd1);
        chk("flush_pre_addr", mem_req ? mem_addr : 32'hFFFF_FFFF, 32'h0000_0685);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("flush_mem_req", 32'(mem_req), 32'd0);
        chk("flush_drain_busy", 32'(busy), 32'd1);
        chk("flush_inst_valid", 32'(inst_valid), 32'd0);
        step();
        chk("flush_idle_busy", 32'(busy), 32'd0);
        chk("flush_idle_req", 32'(mem_req), 32'd0);
        do_miss(32'h0000_0684, 1'b0, 19, "refetch");

        req_valid = 1'b1;
        req_pc    = 32'h0000_1230;
        step();
        chk("postflush_miss", mem_req ? mem_addr : 32'hFFFF_FFFF, 32'h0000_1230);
        req_valid = 1'b0;
        repeat (3) step();
        #6;
        rst_in = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_inst_valid", 32'(inst_valid), 32'd0);
        #1;
        rst_in = 1'b0;
        step();
        chk("late_byte_busy", 32'(busy), 32'd0);
        chk("late_byte_req", 32'(mem_req), 32'd0);
        step();
        chk("late_byte_busy2", 32'(busy), 32'd0);
        chk("late_byte_req2", 32'(mem_req), 32'd0);
        chk("late_byte_valid2", 32'(inst_valid), 32'd0);
        do_miss(32'h0000_1234, 1'b0, 19, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
